sc_axi2regbus: RTL and testbench

AXI4-Lite slave to Space Cubics register bus master bridge. Sits directly upstream of the register bus: it converts AXI4-Lite write and read transactions into register bus write-channel and read-channel accesses. It drives the `busip` side of `sc_regbus_if`, and the register block owns the `regif` side. Write and read channels run independently and may be active at the same time, matching the register bus's separate W/R channels.

---
 rtl/sc_regbus_pkg.sv | 11 +
 rtl/sc_regbus_if.sv | 28 ++
 rtl/sc_regbus_tmo.sv | 37 +++
 rtl/sc_axi2regbus.sv | 203 ++++++++++++++++++++
 tb/tb_sc_axi2regbus.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sc_regbus_pkg.sv
// Shared types and constants for the Space Cubics register bus and its AXI4-Lite bridge.
package sc_regbus_pkg;

  typedef enum logic [1:0] {W_IDLE, W_BUS, W_RESP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_BUS, R_RESP} rd_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam int         REGBUS_TYP_W = 10;

endpackage

// File: rtl/sc_regbus_if.sv
// Register bus with independent write and read channels; busip is the master, regif the register block.
interface sc_regbus_if;

  logic [31:0]                           WADR;
  logic [3:0]                            WENB;
  logic [sc_regbus_pkg::REGBUS_TYP_W-1:0] WTYP;
  logic [31:0]                           WDAT;
  logic                                  WWAT;
  logic                                  WERR;

  logic [31:0]                           RADR;
  logic [3:0]                            RENB;
  logic [sc_regbus_pkg::REGBUS_TYP_W-1:0] RTYP;
  logic [31:0]                           RDAT;
  logic                                  RWAT;
  logic                                  RERR;

  modport busip (
    output WADR, WENB, WTYP, WDAT, RADR, RENB, RTYP,
    input  WWAT, WERR, RDAT, RWAT, RERR
  );

  modport regif (
    input  WADR, WENB, WTYP, WDAT, RADR, RENB, RTYP,
    output WWAT, WERR, RDAT, RWAT, RERR
  );

endinterface

// File: rtl/sc_regbus_tmo.sv
// Wait-state watchdog for one register bus channel: fires on the TIMEOUT-th consecutive wait cycle.
module sc_regbus_tmo #(
  parameter int TIMEOUT = 255
) (
  input  logic CLK,
  input  logic RESET,
  input  logic clr,
  input  logic wat,
  output logic expired
);

  // The counter holds the number of earlier wait cycles, so it never needs to reach TIMEOUT itself.
  localparam int            CW   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (wat && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (TIMEOUT != 0) && wat && !clr && (cnt_q == LAST);

endmodule

// File: rtl/sc_axi2regbus.sv
// AXI4-Lite slave to register bus master bridge; write and read channels run as independent FSMs.
module sc_axi2regbus
  import sc_regbus_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] S_AWADDR,
  input  logic [2:0]  S_AWPROT,
  input  logic        S_AWVALID,
  output logic        S_AWREADY,
  input  logic [31:0] S_WDATA,
  input  logic [3:0]  S_WSTRB,
  input  logic        S_WVALID,
  output logic        S_WREADY,
  output logic [1:0]  S_BRESP,
  output logic        S_BVALID,
  input  logic        S_BREADY,
  input  logic [31:0] S_ARADDR,
  input  logic [2:0]  S_ARPROT,
  input  logic        S_ARVALID,
  output logic        S_ARREADY,
  output logic [31:0] S_RDATA,
  output logic [1:0]  S_RRESP,
  output logic        S_RVALID,
  input  logic        S_RREADY,
  sc_regbus_if.busip  REGBUS
);

  // Handshakes: a beat transfers on a rising edge where valid and ready are both high; responses
  // hold valid and data until accepted. RESET gates every handshake output and bus enable at once.

  wr_state_t   wr_state_q, wr_state_d;
  logic        aw_got_q, aw_got_d, w_got_q, w_got_d;
  logic [29:0] waddr_q, waddr_d;
  logic [2:0]  awprot_q, awprot_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        aw_hs, w_hs, w_tmo;

  rd_state_t   rd_state_q, rd_state_d;
  logic [29:0] raddr_q, raddr_d;
  logic [2:0]  arprot_q, arprot_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic        ar_hs, r_tmo;

  logic        unused_addr_bits;
  assign unused_addr_bits = ^{S_AWADDR[1:0], S_ARADDR[1:0]};

  assign S_AWREADY = !RESET && (wr_state_q == W_IDLE) && !aw_got_q;
  assign S_WREADY  = !RESET && (wr_state_q == W_IDLE) && !w_got_q;
  assign S_BVALID  = !RESET && (wr_state_q == W_RESP);
  assign S_BRESP   = bresp_q;
  assign aw_hs     = S_AWVALID && S_AWREADY;
  assign w_hs      = S_WVALID && S_WREADY;

  assign S_ARREADY = !RESET && (rd_state_q == R_IDLE);
  assign S_RVALID  = !RESET && (rd_state_q == R_RESP);
  assign S_RRESP   = rresp_q;
  assign S_RDATA   = rdata_q;
  assign ar_hs     = S_ARVALID && S_ARREADY;

  assign REGBUS.WADR = {waddr_q, 2'b00};
  assign REGBUS.WDAT = wdata_q;
  assign REGBUS.WTYP = {{(REGBUS_TYP_W-3){1'b0}}, awprot_q};
  assign REGBUS.WENB = (!RESET && (wr_state_q == W_BUS)) ? wstrb_q : 4'h0;
  assign REGBUS.RADR = {raddr_q, 2'b00};
  assign REGBUS.RTYP = {{(REGBUS_TYP_W-3){1'b0}}, arprot_q};
  assign REGBUS.RENB = (!RESET && (rd_state_q == R_BUS)) ? 4'hF : 4'h0;

  always_comb begin
    wr_state_d = wr_state_q;
    aw_got_d   = aw_got_q;
    w_got_d    = w_got_q;
    waddr_d    = waddr_q;
    awprot_d   = awprot_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bresp_d    = bresp_q;
    case (wr_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_got_d = 1'b1;
          waddr_d  = S_AWADDR[31:2];
          awprot_d = S_AWPROT;
        end
        if (w_hs) begin
          w_got_d = 1'b1;
          wdata_d = S_WDATA;
          wstrb_d = S_WSTRB;
        end
        if (aw_got_d && w_got_d) begin
          aw_got_d = 1'b0;
          w_got_d  = 1'b0;
          // An all-zero strobe writes nothing, so it is acknowledged without touching the bus.
          if (wstrb_d == 4'h0) begin
            bresp_d    = RESP_OKAY;
            wr_state_d = W_RESP;
          end else begin
            wr_state_d = W_BUS;
          end
        end
      end
      W_BUS: begin
        if (!REGBUS.WWAT) begin
          bresp_d    = REGBUS.WERR ? RESP_SLVERR : RESP_OKAY;
          wr_state_d = W_RESP;
        end else if (w_tmo) begin
          bresp_d    = RESP_SLVERR;
          wr_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (S_BREADY) wr_state_d = W_IDLE;
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    rd_state_d = rd_state_q;
    raddr_d    = raddr_q;
    arprot_d   = arprot_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    case (rd_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          raddr_d    = S_ARADDR[31:2];
          arprot_d   = S_ARPROT;
          rd_state_d = R_BUS;
        end
      end
      R_BUS: begin
        if (!REGBUS.RWAT) begin
          rdata_d    = REGBUS.RDAT;
          rresp_d    = REGBUS.RERR ? RESP_SLVERR : RESP_OKAY;
          rd_state_d = R_RESP;
        end else if (r_tmo) begin
          rdata_d    = 32'h0;
          rresp_d    = RESP_SLVERR;
          rd_state_d = R_RESP;
        end
      end
      R_RESP: begin
        if (S_RREADY) rd_state_d = R_IDLE;
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_state_q <= W_IDLE;
      aw_got_q   <= 1'b0;
      w_got_q    <= 1'b0;
      waddr_q    <= '0;
      awprot_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= RESP_OKAY;
      rd_state_q <= R_IDLE;
      raddr_q    <= '0;
      arprot_q   <= '0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      wr_state_q <= wr_state_d;
      aw_got_q   <= aw_got_d;
      w_got_q    <= w_got_d;
      waddr_q    <= waddr_d;
      awprot_q   <= awprot_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bresp_q    <= bresp_d;
      rd_state_q <= rd_state_d;
      raddr_q    <= raddr_d;
      arprot_q   <= arprot_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  sc_regbus_tmo #(.TIMEOUT(TIMEOUT)) u_wr_tmo (
    .CLK     (CLK),
    .RESET   (RESET),
    .clr     (wr_state_q != W_BUS),
    .wat     ((wr_state_q == W_BUS) && REGBUS.WWAT),
    .expired (w_tmo)
  );

  sc_regbus_tmo #(.TIMEOUT(TIMEOUT)) u_rd_tmo (
    .CLK     (CLK),
    .RESET   (RESET),
    .clr     (rd_state_q != R_BUS),
    .wat     ((rd_state_q == R_BUS) && REGBUS.RWAT),
    .expired (r_tmo)
  );

endmodule

// File: tb/tb_sc_axi2regbus.sv
// Directed and randomized bench for sc_axi2regbus with a register-block responder and a transaction-level model.
module tb_sc_axi2regbus;

  localparam int TMO = 4;

  logic        CLK, RESET;
  logic [31:0] S_AWADDR, S_WDATA, S_ARADDR, S_RDATA;
  logic [2:0]  S_AWPROT, S_ARPROT;
  logic [3:0]  S_WSTRB;
  logic [1:0]  S_BRESP, S_RRESP;
  logic        S_AWVALID, S_AWREADY, S_WVALID, S_WREADY, S_BVALID, S_BREADY;
  logic        S_ARVALID, S_ARREADY, S_RVALID, S_RREADY;

  sc_regbus_if bus ();

  sc_axi2regbus #(.TIMEOUT(TMO)) dut (
    .CLK(CLK), .RESET(RESET),
    .S_AWADDR(S_AWADDR), .S_AWPROT(S_AWPROT), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
    .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
    .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
    .S_ARADDR(S_ARADDR), .S_ARPROT(S_ARPROT), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
    .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY),
    .REGBUS(bus)
  );

  // ---------------- clock / reset / cycle count ----------------
  int cyc = 0;
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [1:0]  exp_b_q[$];
  logic [33:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: an access waiting 'waits' cycles either completes after waits+1 active
  // cycles or is aborted after TMO active cycles.
  function automatic bit model_timeout(input int waits);
    return (TMO != 0) && (waits >= TMO);
  endfunction

  function automatic int model_active(input int waits);
    return model_timeout(waits) ? TMO : waits + 1;
  endfunction

  // ---------------- register-block responders ----------------
  int          w_waits = 0, r_waits = 0;
  logic        w_err = 1'b0, r_err = 1'b0;
  logic [31:0] r_dat = '0;
  int          w_cnt = 0, r_cnt = 0, w_last_cnt = 0, r_last_cnt = 0;
  logic [31:0] w_first_adr, w_first_dat, r_first_adr;
  logic [3:0]  w_first_enb, r_first_enb;
  logic [9:0]  w_first_typ, r_first_typ;
  logic        w_unstable = 1'b0, r_unstable = 1'b0;

  initial begin
    bus.WWAT = 1'b0; bus.WERR = 1'b0;
    forever begin
      @(posedge CLK); #2;
      if (bus.WENB != 4'h0) begin
        if (w_cnt == 0) begin
          w_first_adr = bus.WADR; w_first_dat = bus.WDAT;
          w_first_enb = bus.WENB; w_first_typ = bus.WTYP;
        end else if (bus.WADR != w_first_adr || bus.WDAT != w_first_dat ||
                     bus.WENB != w_first_enb || bus.WTYP != w_first_typ) begin
          w_unstable = 1'b1;
        end
        w_cnt++;
        bus.WWAT = (w_cnt <= w_waits);
        bus.WERR = (w_cnt > w_waits) ? w_err : 1'($urandom_range(0, 1));
      end else begin
        if (w_cnt != 0) w_last_cnt = w_cnt;
        w_cnt = 0;
        bus.WWAT = 1'($urandom_range(0, 1));
        bus.WERR = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin
    bus.RWAT = 1'b0; bus.RERR = 1'b0; bus.RDAT = '0;
    forever begin
      @(posedge CLK); #2;
      if (bus.RENB != 4'h0) begin
        if (r_cnt == 0) begin
          r_first_adr = bus.RADR; r_first_enb = bus.RENB; r_first_typ = bus.RTYP;
        end else if (bus.RADR != r_first_adr || bus.RENB != r_first_enb ||
                     bus.RTYP != r_first_typ) begin
          r_unstable = 1'b1;
        end
        r_cnt++;
        bus.RWAT = (r_cnt <= r_waits);
        bus.RDAT = (r_cnt > r_waits) ? r_dat : $urandom;
        bus.RERR = (r_cnt > r_waits) ? r_err : 1'($urandom_range(0, 1));
      end else begin
        if (r_cnt != 0) r_last_cnt = r_cnt;
        r_cnt = 0;
        bus.RWAT = 1'($urandom_range(0, 1));
        bus.RDAT = $urandom;
        bus.RERR = 1'($urandom_range(0, 1));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // skew: 0 = AW and W together, 1 = AW one cycle before W, 2 = W one cycle before AW.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input logic [2:0] prot, input int skew, input int waits,
                          input logic err, input int bdelay);
    int         act, t, hs_cyc;
    bit         aw_done, w_done, a, b;
    logic [1:0] resp, got;
    act  = (strb == 4'h0) ? 0 : model_active(waits);
    resp = (strb == 4'h0) ? 2'b00 : ((model_timeout(waits) || err) ? 2'b10 : 2'b00);
    exp_b_q.push_back(resp);
    w_waits = waits; w_err = err; w_last_cnt = 0; w_unstable = 1'b0;
    @(posedge CLK); #1;
    S_AWADDR = addr; S_AWPROT = prot; S_WDATA = data; S_WSTRB = strb;
    S_AWVALID = (skew != 2); S_WVALID = (skew != 1);
    aw_done = 0; w_done = 0; t = 0; hs_cyc = 0;
    while (!(aw_done && w_done) && t < 20) begin
      @(negedge CLK);
      a = S_AWVALID && S_AWREADY; b = S_WVALID && S_WREADY; hs_cyc = cyc;
      @(posedge CLK); #1;
      if (a) begin S_AWVALID = 1'b0; aw_done = 1; end
      if (b) begin S_WVALID = 1'b0; w_done = 1; end
      if (skew == 1 && aw_done && !w_done) S_WVALID = 1'b1;
      if (skew == 2 && w_done && !aw_done) S_AWVALID = 1'b1;
      t++;
    end
    check("wr_addr_data_accepted", 32'(aw_done && w_done), 32'd1);
    t = 0;
    @(negedge CLK);
    while (!S_BVALID && t < 60) begin
      check("wr_awready_low_in_bus", 32'(S_AWREADY), 32'd0);
      @(negedge CLK); t++;
    end
    check("wr_bvalid_seen", 32'(S_BVALID), 32'd1);
    check("wr_latency", 32'(cyc - hs_cyc), 32'(1 + act));
    got = exp_b_q.pop_front();
    check("wr_bresp", 32'(S_BRESP), 32'(got));
    check("wr_active_cycles", 32'(w_last_cnt), 32'(act));
    if (act > 0) begin
      check("wr_wadr", w_first_adr, {addr[31:2], 2'b00});
      check("wr_wdat", w_first_dat, data);
      check("wr_wenb", 32'(w_first_enb), 32'(strb));
      check("wr_wtyp", 32'(w_first_typ), 32'(prot));
      check("wr_bus_stable", 32'(w_unstable), 32'd0);
    end
    for (int i = 0; i < bdelay; i++) begin
      @(negedge CLK);
      check("wr_bvalid_hold", 32'(S_BVALID), 32'd1);
      check("wr_bresp_hold", 32'(S_BRESP), 32'(got));
      check("wr_no_awready_before_bready", 32'(S_AWREADY), 32'd0);
    end
    @(posedge CLK); #1; S_BREADY = 1'b1;
    @(posedge CLK); #1; S_BREADY = 1'b0;
    @(negedge CLK);
    check("wr_bvalid_dropped", 32'(S_BVALID), 32'd0);
    check("wr_awready_back", 32'(S_AWREADY), 32'd1);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [2:0] prot, input int waits,
                         input logic err, input logic [31:0] dat, input int rdelay);
    int          act, t, hs_cyc;
    bit          done, a;
    logic [33:0] e;
    act = model_active(waits);
    e   = {(model_timeout(waits) || err) ? 2'b10 : 2'b00, model_timeout(waits) ? 32'h0 : dat};
    exp_q.push_back(e);
    r_waits = waits; r_err = err; r_dat = dat; r_last_cnt = 0; r_unstable = 1'b0;
    @(posedge CLK); #1;
    S_ARADDR = addr; S_ARPROT = prot; S_ARVALID = 1'b1;
    done = 0; t = 0; hs_cyc = 0;
    while (!done && t < 20) begin
      @(negedge CLK);
      a = S_ARVALID && S_ARREADY; hs_cyc = cyc;
      @(posedge CLK); #1;
      if (a) begin S_ARVALID = 1'b0; done = 1; end
      t++;
    end
    check("rd_addr_accepted", 32'(done), 32'd1);
    t = 0;
    @(negedge CLK);
    while (!S_RVALID && t < 60) begin
      check("rd_arready_low_in_bus", 32'(S_ARREADY), 32'd0);
      @(negedge CLK); t++;
    end
    check("rd_rvalid_seen", 32'(S_RVALID), 32'd1);
    check("rd_latency", 32'(cyc - hs_cyc), 32'(1 + act));
    e = exp_q.pop_front();
    check("rd_rresp", 32'(S_RRESP), 32'(e[33:32]));
    check("rd_rdata", S_RDATA, e[31:0]);
    check("rd_active_cycles", 32'(r_last_cnt), 32'(act));
    check("rd_radr", r_first_adr, {addr[31:2], 2'b00});
    check("rd_renb", 32'(r_first_enb), 32'hF);
    check("rd_rtyp", 32'(r_first_typ), 32'(prot));
    check("rd_bus_stable", 32'(r_unstable), 32'd0);
    for (int i = 0; i < rdelay; i++) begin
      @(negedge CLK);
      check("rd_rvalid_hold", 32'(S_RVALID), 32'd1);
      check("rd_rdata_hold", S_RDATA, e[31:0]);
    end
    @(posedge CLK); #1; S_RREADY = 1'b1;
    @(posedge CLK); #1; S_RREADY = 1'b0;
    @(negedge CLK);
    check("rd_rvalid_dropped", 32'(S_RVALID), 32'd0);
    check("rd_arready_back", 32'(S_ARREADY), 32'd1);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int mode, wt, rt;
    logic [3:0] st;
    RESET = 1'b1;
    S_AWADDR = '0; S_AWPROT = '0; S_AWVALID = 1'b0; S_WDATA = '0; S_WSTRB = '0; S_WVALID = 1'b0;
    S_BREADY = 1'b0; S_ARADDR = '0; S_ARPROT = '0; S_ARVALID = 1'b0; S_RREADY = 1'b0;

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_awready", 32'(S_AWREADY), 32'd0);
    check("rst_wready", 32'(S_WREADY), 32'd0);
    check("rst_arready", 32'(S_ARREADY), 32'd0);
    check("rst_bvalid", 32'(S_BVALID), 32'd0);
    check("rst_rvalid", 32'(S_RVALID), 32'd0);
    check("rst_wenb_renb", 32'({bus.WENB, bus.RENB}), 32'd0);
    check("rst_wadr", bus.WADR, 32'd0);
    check("rst_wdat", bus.WDAT, 32'd0);
    check("rst_radr", bus.RADR, 32'd0);
    check("rst_typ", 32'({bus.WTYP, bus.RTYP}), 32'd0);
    check("rst_resp", 32'({S_BRESP, S_RRESP}), 32'd0);
    check("rst_rdata", S_RDATA, 32'd0);
    @(posedge CLK); #1; RESET = 1'b0;
    @(negedge CLK);
    check("post_rst_ready", 32'({S_AWREADY, S_WREADY, S_ARREADY}), 32'h7);

    do_write(32'h1000_0008, 32'hDEAD_BEEF, 4'hF, 3'd0, 1, 0, 1'b0, 0);
    do_read (32'h0000_0010, 3'd2, 3, 1'b0, 32'h1234_5678, 0);
    do_write(32'h0000_0104, 32'h0BAD_F00D, 4'h3, 3'd5, 0, 1, 1'b1, 1);
    do_read (32'h0000_0020, 3'd1, 0, 1'b1, 32'hCAFE_0001, 2);
    do_write(32'h0000_0200, 32'h5555_AAAA, 4'hF, 3'd0, 2, 100, 1'b0, 0);
    do_read (32'h0000_0300, 3'd0, 100, 1'b0, 32'hFFFF_FFFF, 0);
    do_write(32'h0000_0400, 32'h1111_2222, 4'hC, 3'd3, 0, TMO - 1, 1'b0, 0);
    do_read (32'h0000_0404, 3'd7, TMO - 1, 1'b0, 32'h8765_4321, 0);
    do_write(32'h0000_0500, 32'h3333_4444, 4'h0, 3'd0, 0, 0, 1'b1, 0);
    fork
      do_write(32'h0000_0600, 32'h7777_8888, 4'hF, 3'd6, 0, 2, 1'b0, 5);
      do_read (32'h0000_0604, 3'd4, 1, 1'b0, 32'h9999_0000, 0);
    join

    // Reset while both channels are waiting on the bus.
    w_waits = 100; r_waits = 100;
    @(posedge CLK); #1;
    S_AWADDR = 32'h0000_0700; S_WDATA = 32'hABCD_EF01; S_WSTRB = 4'hF; S_AWPROT = 3'd0;
    S_ARADDR = 32'h0000_0704; S_ARPROT = 3'd0;
    S_AWVALID = 1'b1; S_WVALID = 1'b1; S_ARVALID = 1'b1;
    @(posedge CLK); #1;
    S_AWVALID = 1'b0; S_WVALID = 1'b0; S_ARVALID = 1'b0;
    @(negedge CLK);
    check("mid_rst_wenb_active", 32'(bus.WENB), 32'hF);
    check("mid_rst_renb_active", 32'(bus.RENB), 32'hF);
    @(posedge CLK); #1; RESET = 1'b1;
    @(negedge CLK);
    check("mid_rst_enb_dropped", 32'({bus.WENB, bus.RENB}), 32'd0);
    check("mid_rst_valids_low", 32'({S_BVALID, S_RVALID}), 32'd0);
    @(posedge CLK); #1; RESET = 1'b0;
    @(negedge CLK);
    check("after_rst_enb", 32'({bus.WENB, bus.RENB}), 32'd0);
    check("after_rst_valids", 32'({S_BVALID, S_RVALID}), 32'd0);
    check("after_rst_ready", 32'({S_AWREADY, S_WREADY, S_ARREADY}), 32'h7);
    do_write(32'h0000_0708, 32'h0102_0304, 4'hF, 3'd0, 0, TMO - 1, 1'b0, 0);
    do_read (32'h0000_070C, 3'd0, TMO - 1, 1'b0, 32'h0506_0708, 0);

    for (int n = 0; n < 40; n++) begin
      mode = $urandom_range(0, 2);
      wt   = $urandom_range(0, TMO + 1);
      rt   = $urandom_range(0, TMO + 1);
      st   = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      if (mode == 0) begin
        do_write($urandom, $urandom, st, 3'($urandom_range(0, 7)), $urandom_range(0, 2), wt,
                 1'($urandom_range(0, 1)), $urandom_range(0, 3));
      end else if (mode == 1) begin
        do_read($urandom, 3'($urandom_range(0, 7)), rt, 1'($urandom_range(0, 1)), $urandom,
                $urandom_range(0, 3));
      end else begin
        fork
          do_write($urandom, $urandom, st, 3'($urandom_range(0, 7)), $urandom_range(0, 2), wt,
                   1'($urandom_range(0, 1)), $urandom_range(0, 3));
          do_read($urandom, 3'($urandom_range(0, 7)), rt, 1'($urandom_range(0, 1)), $urandom,
                  $urandom_range(0, 3));
        join
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
